// File: rtl/seq_mult_unit_if.sv
// Handshake and result bus for the iterative multiplier.
// The master side issues start and operands; the slave side returns busy, done and HI/LO.
interface seq_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] fatorA;
    logic [WIDTH-1:0] fatorB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, is_signed, fatorA, fatorB,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, is_signed, fatorA, fatorB,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier (MULT/MULTU) with a fixed WIDTH+1 cycle latency.
// Signed operands are multiplied as magnitudes, and the sign is applied in FINISH.
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    seq_mult_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               neg;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // The most negative value maps to 2^(W-1), which still fits as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag(bus.fatorA, bus.is_signed)};
                        mplier <= mag(bus.fatorB, bus.is_signed);
                        acc    <= '0;
                        count  <= '0;
                        neg    <= bus.is_signed & (bus.fatorA[WIDTH-1] ^ bus.fatorB[WIDTH-1]);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST)
                        state <= FINISH;
                end
                FINISH: begin
                    {hi_q, lo_q} <= neg ? (~acc + 1'b1) : acc;
                    done_q       <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed checks for the 32-bit multiplier, plus a randomized sweep of an
// 8-bit instance against a reference product.
module tb_seq_mult_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_mult_unit_if #(.WIDTH(32)) b32 ();
    seq_mult_unit_if #(.WIDTH(8))  b8 ();

    seq_mult_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    seq_mult_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    // Issue one multiply on the 32-bit unit.
    // Returns the edge count to done (-1 on timeout) and the number of busy samples.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output int bc);
        b32.fatorA = a; b32.fatorB = b; b32.is_signed = s; b32.start = 1'b1;
        @(posedge clk); #1;
        b32.start = 1'b0;
        lat = -1; bc = 0;
        for (int k = 1; k <= 100; k++) begin
            if (b32.busy) bc++;
            @(posedge clk); #1;
            if (b32.done) begin lat = k; break; end
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
        b8.fatorA = a; b8.fatorB = b; b8.is_signed = s; b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (b8.done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        int lat, bc, seen;
        total++; if (b32.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", b32.busy); end
        total++; if (b32.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", b32.done); end
        total++; if ({b32.HI, b32.LO} !== 64'd0) begin bad++; $display("FAIL reset_hilo got=%h want=0", {b32.HI, b32.LO}); end
        // Leave a nonzero result behind so the mid-op reset has something to clear.
        run32(32'hFFFFFFFF, 32'd2, 1'b0, lat, bc);
        total++; if ({b32.HI, b32.LO} !== 64'h1_FFFFFFFE) begin bad++; $display("FAIL pre_reset_result got=%h want=1fffffffe", {b32.HI, b32.LO}); end
        b32.fatorA = 32'd7; b32.fatorB = 32'd6; b32.is_signed = 1'b0; b32.start = 1'b1;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        total++; if (b32.busy !== 1'b0) begin bad++; $display("FAIL midop_busy got=%0b want=0", b32.busy); end
        total++; if (b32.done !== 1'b0) begin bad++; $display("FAIL midop_done got=%0b want=0", b32.done); end
        total++; if ({b32.HI, b32.LO} !== 64'd0) begin bad++; $display("FAIL midop_hilo got=%h want=0", {b32.HI, b32.LO}); end
        @(negedge clk) reset = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (b32.done) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL no_done_after_reset got=%0d want=0", seen); end
        run32(32'd7, 32'd6, 1'b0, lat, bc);
        total++; if (lat != 33) begin bad++; $display("FAIL post_reset_latency got=%0d want=33", lat); end
        total++; if ({b32.HI, b32.LO} !== 64'd42) begin bad++; $display("FAIL post_reset_result got=%h want=2a", {b32.HI, b32.LO}); end
    endtask

    task automatic test_unsigned;
        int lat, bc;
        run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bc);
        total++; if (lat != 33) begin bad++; $display("FAIL unsigned_latency got=%0d want=33", lat); end
        total++; if (bc != 33) begin bad++; $display("FAIL unsigned_busy_cycles got=%0d want=33", bc); end
        total++; if (b32.HI !== 32'hFFFFFFFE) begin bad++; $display("FAIL unsigned_hi got=%h want=fffffffe", b32.HI); end
        total++; if (b32.LO !== 32'h00000001) begin bad++; $display("FAIL unsigned_lo got=%h want=00000001", b32.LO); end
        total++; if (b32.busy !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%0b want=0", b32.busy); end
        @(posedge clk); #1;
        total++; if (b32.done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%0b want=0", b32.done); end
    endtask

    task automatic test_signed;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [63:0] ve [3];
        int lat, bc;
        va[0] = 32'hFFFFFFFD; vb[0] = 32'd5;        ve[0] = 64'hFFFFFFFF_FFFFFFF1;
        va[1] = 32'h80000000; vb[1] = 32'h80000000; ve[1] = 64'h40000000_00000000;
        va[2] = 32'h80000000; vb[2] = 32'd1;        ve[2] = 64'hFFFFFFFF_80000000;
        for (int i = 0; i < 3; i++) begin
            run32(va[i], vb[i], 1'b1, lat, bc);
            total++; if ({b32.HI, b32.LO} !== ve[i] || lat != 33) begin
                bad++; $display("FAIL signed_%0d got=%h lat=%0d want=%h lat=33", i, {b32.HI, b32.LO}, lat, ve[i]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int e;
        b32.fatorA = 32'd3; b32.fatorB = 32'd4; b32.is_signed = 1'b0; b32.start = 1'b1;
        @(posedge clk); #1;
        b32.start = 1'b0;
        e = 0;
        repeat (4) begin @(posedge clk); e++; end
        #1;
        b32.fatorA = 32'd100; b32.fatorB = 32'd100; b32.is_signed = 1'b1; b32.start = 1'b1;
        @(posedge clk); e++; #1;
        b32.start = 1'b0;
        while (!b32.done && e < 100) begin @(posedge clk); e++; #1; end
        total++; if (e != 33) begin bad++; $display("FAIL ignore_start_latency got=%0d want=33", e); end
        total++; if ({b32.HI, b32.LO} !== 64'd12) begin bad++; $display("FAIL ignore_start_result got=%h want=c", {b32.HI, b32.LO}); end
    endtask

    task automatic test_back_to_back;
        int e;
        b32.fatorA = 32'd5; b32.fatorB = 32'd6; b32.is_signed = 1'b0; b32.start = 1'b1;
        @(posedge clk); #1;
        b32.fatorA = 32'd9; b32.fatorB = 32'd11;
        e = 0;
        while (!b32.done && e < 100) begin @(posedge clk); e++; #1; end
        total++; if (e != 33 || {b32.HI, b32.LO} !== 64'd30) begin
            bad++; $display("FAIL b2b_first got=%h lat=%0d want=1e lat=33", {b32.HI, b32.LO}, e);
        end
        @(posedge clk); #1;
        b32.start = 1'b0;
        total++; if (b32.done !== 1'b0 || b32.busy !== 1'b1) begin
            bad++; $display("FAIL b2b_accept done=%0b busy=%0b want done=0 busy=1", b32.done, b32.busy);
        end
        e = 0;
        while (!b32.done && e < 100) begin @(posedge clk); e++; #1; end
        total++; if (e != 33) begin bad++; $display("FAIL b2b_second_latency got=%0d want=33", e); end
        total++; if ({b32.HI, b32.LO} !== 64'd99) begin bad++; $display("FAIL b2b_second_result got=%h want=63", {b32.HI, b32.LO}); end
    endtask

    task automatic test_zero_identity;
        int lat, bc;
        run32(32'd0, 32'h12345678, 1'b0, lat, bc);
        total++; if ({b32.HI, b32.LO} !== 64'd0 || lat != 33) begin
            bad++; $display("FAIL zero got=%h lat=%0d want=0 lat=33", {b32.HI, b32.LO}, lat);
        end
        run32(32'd1, 32'h12345678, 1'b0, lat, bc);
        total++; if ({b32.HI, b32.LO} !== 64'h12345678 || lat != 33) begin
            bad++; $display("FAIL identity got=%h lat=%0d want=12345678 lat=33", {b32.HI, b32.LO}, lat);
        end
    endtask

    task automatic test_width8;
        logic [7:0]        a, b;
        logic signed [7:0] sa, sb;
        logic              s;
        logic [15:0]       exp;
        int                lat, prod;
        for (int i = 0; i < 1002; i++) begin
            if (i == 0)      begin a = 8'h80; b = 8'h80; s = 1'b1; end
            else if (i == 1) begin a = 8'hFF; b = 8'hFF; s = 1'b0; end
            else begin
                a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            end
            sa = a; sb = b;
            prod = s ? int'(sa) * int'(sb) : int'(a) * int'(b);
            exp = 16'(prod);
            run8(a, b, s, lat);
            total++; if ({b8.HI, b8.LO} !== exp || lat != 9) begin
                bad++; $display("FAIL w8_%0d a=%h b=%h s=%0b got=%h lat=%0d want=%h lat=9",
                                i, a, b, s, {b8.HI, b8.LO}, lat, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        b32.start = 1'b0; b32.is_signed = 1'b0; b32.fatorA = '0; b32.fatorB = '0;
        b8.start  = 1'b0; b8.is_signed  = 1'b0; b8.fatorA  = '0; b8.fatorB  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset_prep();
        test_reset();
        test_unsigned();
        test_signed();
        test_start_while_busy();
        test_back_to_back();
        test_zero_identity();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Release the power-on reset away from a clock edge.
    task automatic test_reset_prep;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
    endtask
endmodule
